// File: rtl/sort4_frame_ser.sv
// Serialises a snapshot of four sorted entries into a first/last-marked byte frame on a valid/ready stream.
// Optional trailing checksum byte when CHKSUM_EN is defined (default build: 4-byte frame, no CSUM state).
module sort4_frame_ser #(
   parameter int W   = 8,
   parameter bit ASC = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] ra,
   input  logic [W-1:0] rb,
   input  logic [W-1:0] rc,
   input  logic [W-1:0] rd,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         dout_first,
   output logic         dout_last,
   output logic         busy,
   output logic         ord_err,
   output logic [7:0]   frame_cnt,
   output logic [1:0]   dbg_state_o
);

   // Stream handshake: a byte moves on a rising edge where dout_valid & dout_ready;
   // while dout_valid is high and dout_ready is low, dout/first/last hold unchanged.

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
`ifdef CHKSUM_EN
   localparam logic [1:0] CSUM = 2'd2;
`endif

   logic [1:0]   state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [W-1:0] snap_q [4];
   logic [W-1:0] snap_d [4];
   logic [W-1:0] dout_q, dout_d;
   logic         valid_q, valid_d;
   logic         first_q, first_d;
   logic         last_q, last_d;
   logic         ord_err_q, ord_err_d;
   logic [7:0]   frame_cnt_q, frame_cnt_d;

   logic         transfer;
   logic [1:0]   nxt_idx;
   logic [1:0]   nxt_sel;
`ifdef CHKSUM_EN
   logic [W-1:0] csum;
`endif

   assign transfer = valid_q & dout_ready;
   assign nxt_idx  = idx_q + 2'd1;
   // Snapshot slot 0 holds ra; ascending order walks the slots backwards.
   assign nxt_sel  = ASC ? (2'd3 - nxt_idx) : nxt_idx;
`ifdef CHKSUM_EN
   assign csum     = snap_q[0] + snap_q[1] + snap_q[2] + snap_q[3];
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      dout_d      = dout_q;
      valid_d     = valid_q;
      first_d     = first_q;
      last_d      = last_q;
      ord_err_d   = ord_err_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         IDLE: begin
            if (load) begin
               snap_d[0] = ra;
               snap_d[1] = rb;
               snap_d[2] = rc;
               snap_d[3] = rd;
               idx_d     = 2'd0;
               state_d   = SEND;
               valid_d   = 1'b1;
               dout_d    = ASC ? rd : ra;
               first_d   = 1'b1;
               last_d    = 1'b0;
               ord_err_d = (ra < rb) | (rb < rc) | (rc < rd);
            end
         end
         SEND: begin
            if (transfer) begin
               if (idx_q != 2'd3) begin
                  idx_d   = nxt_idx;
                  dout_d  = snap_q[nxt_sel];
                  first_d = 1'b0;
`ifdef CHKSUM_EN
                  last_d  = 1'b0;
`else
                  last_d  = (nxt_idx == 2'd3);
`endif
               end else begin
`ifdef CHKSUM_EN
                  state_d = CSUM;
                  dout_d  = csum;
                  first_d = 1'b0;
                  last_d  = 1'b1;
`else
                  state_d     = IDLE;
                  valid_d     = 1'b0;
                  last_d      = 1'b0;
                  frame_cnt_d = frame_cnt_q + 8'd1;
`endif
               end
            end
         end
`ifdef CHKSUM_EN
         CSUM: begin
            if (transfer) begin
               state_d     = IDLE;
               valid_d     = 1'b0;
               last_d      = 1'b0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         for (int i = 0; i < 4; i++) snap_q[i] <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         ord_err_q   <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         first_q     <= first_d;
         last_q      <= last_d;
         ord_err_q   <= ord_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign dout        = dout_q;
   assign dout_valid  = valid_q;
   assign dout_first  = first_q;
   assign dout_last   = last_q;
   assign busy        = (state_q != IDLE);
   assign ord_err     = ord_err_q;
   assign frame_cnt   = frame_cnt_q;
   assign dbg_state_o = state_q;

endmodule
